// File: rtl/atb_pkg.sv
// Shared types and helpers for the ATB trace funnel: beat layout, arbiter states and
// the reserved-ATID test.
package atb_pkg;

    localparam int ATB_ATID_W = 8;
    localparam int ATB_DATA_W = 64;

    localparam logic [31:0] ATID_RSV_LO = 32'h70;
    localparam logic [31:0] ATID_RSV_HI = 32'h7F;

    typedef struct packed {
        logic [ATB_ATID_W-1:0] atid;
        logic [ATB_DATA_W-1:0] atdata;
        logic                  atlast;
    } atb_beat_t;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    // ID 0x00 and 0x70-0x7F are reserved; wider IDs must have their upper bits clear to match.
    function automatic logic atid_reserved(input logic [31:0] atid);
        return (atid == 32'd0) || ((atid >= ATID_RSV_LO) && (atid <= ATID_RSV_HI));
    endfunction

endpackage

// File: rtl/atb_skid_buf.sv
// Two-entry valid/ready register slice. A beat written in one cycle is presented the next;
// the output holds steady while the consumer stalls.
module atb_skid_buf
    import atb_pkg::*;
#(
    parameter type T = atb_beat_t
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic in_valid_i,
    output logic in_ready_o,
    input  T     in_data_i,
    output logic out_valid_o,
    input  logic out_ready_i,
    output T     out_data_o,
    output logic empty_o
);

    T           mem [2];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;

    assign in_ready_o  = (count != 2'd2);
    assign out_valid_o = (count != 2'd0);
    assign empty_o     = (count == 2'd0);
    assign out_data_o  = mem[rd_ptr];
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data_i;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/atb_funnel_arbiter.sv
// Packet-aware round-robin funnel: NUM_SRC ATB sources onto one sink, grant locked per
// packet with a HOLD_MAX beat cap, reserved-ATID beats dropped, flush handshake.
module atb_funnel_arbiter
    import atb_pkg::*;
#(
    parameter int NUM_SRC    = 6,
    parameter int DATA_WIDTH = 64,
    parameter int ATID_WIDTH = 8,
    parameter int HOLD_MAX   = 16
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NUM_SRC-1:0]                    src_en_i,
    input  logic                                  flush_req_i,
    output logic                                  flush_done_o,
    input  logic [NUM_SRC-1:0][ATID_WIDTH-1:0]    s_atid_i,
    input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]    s_atdata_i,
    input  logic [NUM_SRC-1:0]                    s_atlast_i,
    input  logic [NUM_SRC-1:0]                    s_atvalid_i,
    output logic [NUM_SRC-1:0]                    s_atready_o,
    output logic [ATID_WIDTH-1:0]                 m_atid_o,
    output logic [DATA_WIDTH-1:0]                 m_atdata_o,
    output logic                                  m_atlast_o,
    output logic                                  m_atvalid_o,
    input  logic                                  m_atready_i,
    output logic [$clog2(NUM_SRC)-1:0]            grant_idx_o,
    output logic                                  busy_o,
    output logic [15:0]                           drop_cnt_o
);

    localparam int IDX_W = $clog2(NUM_SRC);
    localparam int CNT_W = $clog2(HOLD_MAX + 1);

    typedef struct packed {
        logic [ATID_WIDTH-1:0] atid;
        logic [DATA_WIDTH-1:0] atdata;
        logic                  atlast;
    } beat_t;

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   g_q, g_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               flush_pend_q, flush_pend_d;
    logic [15:0]        drop_cnt_q, drop_cnt_d;

    logic [NUM_SRC-1:0] req;
    logic               accept;
    logic               reserved;
    logic               push;
    logic               flush_done;
    beat_t              in_beat;
    beat_t              out_beat;
    logic               skid_in_ready;
    logic               skid_empty;

    // Lowest-numbered requester strictly after ptr, wrapping; ptr itself is checked last.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_SRC-1:0] r,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            idx = (int'(ptr) + i) % NUM_SRC;
            if (!found && r[idx]) begin
                pick  = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Every ATB port transfers a beat on a cycle where valid and ready are both high; valid,
    // once raised, holds with stable payload until that cycle, and ready never waits on valid
    // being low.
    always_comb begin
        state_d      = state_q;
        g_d          = g_q;
        rr_d         = rr_q;
        cnt_d        = cnt_q;
        drop_cnt_d   = drop_cnt_q;
        s_atready_o  = '0;
        accept       = 1'b0;
        push         = 1'b0;
        req          = s_atvalid_i & src_en_i;
        reserved     = atid_reserved(32'(s_atid_i[g_q]));
        in_beat.atid   = s_atid_i[g_q];
        in_beat.atdata = s_atdata_i[g_q];
        in_beat.atlast = s_atlast_i[g_q];

        case (state_q)
            IDLE: begin
                if (|req) begin
                    g_d     = rr_pick(req, rr_q);
                    state_d = XFER;
                end
            end
            XFER: begin
                s_atready_o[g_q] = skid_in_ready;
                accept           = s_atvalid_i[g_q] & skid_in_ready;
                if (accept) begin
                    push = !reserved;
                    if (reserved && (drop_cnt_q != 16'hFFFF)) begin
                        drop_cnt_d = drop_cnt_q + 16'd1;
                    end
                    // Packet end or burst cap hands the port back; rr_ptr makes g lowest priority.
                    if (s_atlast_i[g_q] || (cnt_q == CNT_W'(HOLD_MAX - 1))) begin
                        state_d = IDLE;
                        rr_d    = g_q;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        flush_done   = flush_pend_q && (state_q == IDLE) && !(|req) && skid_empty;
        flush_pend_d = flush_req_i | (flush_pend_q & ~flush_done);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            g_q          <= '0;
            rr_q         <= IDX_W'(NUM_SRC - 1);
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            g_q          <= g_d;
            rr_q         <= rr_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    atb_skid_buf #(
        .T (beat_t)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (push),
        .in_ready_o  (skid_in_ready),
        .in_data_i   (in_beat),
        .out_valid_o (m_atvalid_o),
        .out_ready_i (m_atready_i),
        .out_data_o  (out_beat),
        .empty_o     (skid_empty)
    );

    assign m_atid_o     = out_beat.atid;
    assign m_atdata_o   = out_beat.atdata;
    assign m_atlast_o   = out_beat.atlast;
    assign grant_idx_o  = g_q;
    assign busy_o       = (state_q != IDLE) || !skid_empty;
    assign drop_cnt_o   = drop_cnt_q;
    assign flush_done_o = flush_done;

endmodule

// File: tb/tb_atb_funnel_arbiter.sv
// Directed bench for atb_funnel_arbiter: per-source beat queues feed the ports, a scoreboard
// queue holds the sink beats in the order arbitration must produce them.
module tb_atb_funnel_arbiter;

    localparam int NUM_SRC = 6;
    localparam int DW      = 64;
    localparam int IW      = 8;

    typedef struct packed {
        logic [IW-1:0] atid;
        logic [DW-1:0] data;
        logic          last;
    } tb_beat_t;

    logic                       clk;
    logic                       rst_i;
    logic [NUM_SRC-1:0]         src_en;
    logic                       flush_req;
    logic                       flush_done;
    logic [NUM_SRC-1:0][IW-1:0] s_atid;
    logic [NUM_SRC-1:0][DW-1:0] s_atdata;
    logic [NUM_SRC-1:0]         s_atlast;
    logic [NUM_SRC-1:0]         s_atvalid;
    logic [NUM_SRC-1:0]         s_atready;
    logic [IW-1:0]              m_atid;
    logic [DW-1:0]              m_atdata;
    logic                       m_atlast;
    logic                       m_atvalid;
    logic                       m_atready;
    logic [2:0]                 grant_idx;
    logic                       busy;
    logic [15:0]                drop_cnt;

    tb_beat_t           src_q [NUM_SRC][$];
    tb_beat_t           exp_q [$];
    logic [NUM_SRC-1:0] acc_prev;
    int                 acc_cnt [NUM_SRC];
    int                 stall_cnt;
    logic               rst_v;
    logic               flush_v;
    logic               mon_en;
    logic               stall_prev;
    tb_beat_t           held;
    int                 vectors;
    int                 miscompares;

    atb_funnel_arbiter #(
        .NUM_SRC    (NUM_SRC),
        .DATA_WIDTH (DW),
        .ATID_WIDTH (IW),
        .HOLD_MAX   (16)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .src_en_i     (src_en),
        .flush_req_i  (flush_req),
        .flush_done_o (flush_done),
        .s_atid_i     (s_atid),
        .s_atdata_i   (s_atdata),
        .s_atlast_i   (s_atlast),
        .s_atvalid_i  (s_atvalid),
        .s_atready_o  (s_atready),
        .m_atid_o     (m_atid),
        .m_atdata_o   (m_atdata),
        .m_atlast_o   (m_atlast),
        .m_atvalid_o  (m_atvalid),
        .m_atready_i  (m_atready),
        .grant_idx_o  (grant_idx),
        .busy_o       (busy),
        .drop_cnt_o   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input int src, input int seq);
        return {8'(src), 24'h0, 32'(seq)};
    endfunction

    function automatic logic is_rsv(input logic [IW-1:0] atid);
        return (atid == 8'h00) || (atid >= 8'h70 && atid <= 8'h7F);
    endfunction

    function automatic logic srcs_empty();
        logic e;
        e = 1'b1;
        for (int s = 0; s < NUM_SRC; s++) if (src_q[s].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic push_beat(input int src, input logic [IW-1:0] atid, input int seq, input logic last);
        tb_beat_t b;
        b.atid = atid;
        b.data = mk_data(src, seq);
        b.last = last;
        src_q[src].push_back(b);
        if (!is_rsv(atid)) exp_q.push_back(b);
    endtask

    task automatic send_pkt(input int src, input int n, input int seq0);
        for (int i = 0; i < n; i++) push_beat(src, 8'(8'h10 + src), seq0 + i, (i == n - 1));
    endtask

    // One clock: drive just after the edge, sample and score at the falling edge.
    task automatic tick();
        tb_beat_t cur;
        tb_beat_t tmp;
        @(posedge clk);
        #1;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (acc_prev[s] && src_q[s].size() > 0) begin
                tmp = src_q[s].pop_front();
                acc_cnt[s]++;
            end
            if (src_q[s].size() > 0) begin
                s_atvalid[s] = 1'b1;
                s_atid[s]    = src_q[s][0].atid;
                s_atdata[s]  = src_q[s][0].data;
                s_atlast[s]  = src_q[s][0].last;
            end else begin
                s_atvalid[s] = 1'b0;
                s_atid[s]    = '0;
                s_atdata[s]  = '0;
                s_atlast[s]  = 1'b0;
            end
        end
        m_atready = (stall_cnt == 0);
        if (stall_cnt > 0) stall_cnt--;
        flush_req = flush_v;
        flush_v   = 1'b0;
        rst_i     = rst_v;
        @(negedge clk);
        cur.atid = m_atid;
        cur.data = m_atdata;
        cur.last = m_atlast;
        if (mon_en && stall_prev) check("stall_stable", 96'(cur), 96'(held));
        if (mon_en && m_atvalid === 1'b1 && m_atready) begin
            if (exp_q.size() == 0) check("unexpected_beat", 96'(cur), 96'(0));
            else                   check("sink_beat", 96'(cur), 96'(exp_q.pop_front()));
        end
        stall_prev = (m_atvalid === 1'b1) && !m_atready;
        held       = cur;
        acc_prev   = s_atvalid & s_atready;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            done = (exp_q.size() == 0) && (busy === 1'b0) && srcs_empty();
        end
        check(tag, 96'(done), 96'(1));
    endtask

    task automatic do_reset();
        rst_v = 1'b1;
        tick();
        rst_v = 1'b0;
        tick();
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_ready"}, 96'(s_atready), 96'(0));
        check({tag, "_mvalid"}, 96'(m_atvalid), 96'(0));
        check({tag, "_mbeat"}, 96'({m_atid, m_atdata, m_atlast}), 96'(0));
        check({tag, "_grant"}, 96'(grant_idx), 96'(0));
        check({tag, "_busy"}, 96'(busy), 96'(0));
        check({tag, "_drop"}, 96'(drop_cnt), 96'(0));
        check({tag, "_flush"}, 96'(flush_done), 96'(0));
    endtask

    initial begin
        logic seen;
        vectors     = 0;
        miscompares = 0;
        rst_i       = 1'b1;
        rst_v       = 1'b1;
        src_en      = '1;
        flush_req   = 1'b0;
        flush_v     = 1'b0;
        s_atid      = '0;
        s_atdata    = '0;
        s_atlast    = '0;
        s_atvalid   = '0;
        m_atready   = 1'b1;
        stall_cnt   = 0;
        mon_en      = 1'b1;
        stall_prev  = 1'b0;
        held        = '0;
        acc_prev    = '0;
        for (int s = 0; s < NUM_SRC; s++) acc_cnt[s] = 0;

        do_reset();
        reset_checks("reset");

        // Single 3-beat packet from source 2
        send_pkt(2, 3, 0);
        tick();
        tick();
        check("t1_grant", 96'(grant_idx), 96'(2));
        check("t1_busy", 96'(busy), 96'(1));
        tick();
        check("t1_latency", 96'(m_atvalid), 96'(1));
        wait_idle("t1_drain", 50);
        check("t1_idle", 96'(busy), 96'(0));
        check("t1_grant_hold", 96'(grant_idx), 96'(2));

        // Round robin among 0,1,3 with single-beat packets, from a fresh pointer
        do_reset();
        for (int r = 0; r < 2; r++) begin
            push_beat(0, 8'h10, r, 1'b1);
            push_beat(1, 8'h11, r, 1'b1);
            push_beat(3, 8'h13, r, 1'b1);
        end
        wait_idle("t2_drain", 60);

        // Burst cap: source 0 streams without atlast, source 1 waiting
        for (int i = 0; i < 16; i++) push_beat(0, 8'h10, i, 1'b0);
        push_beat(1, 8'h11, 0, 1'b0);
        push_beat(1, 8'h11, 1, 1'b1);
        for (int i = 16; i < 48; i++) push_beat(0, 8'h10, i, (i == 47));
        wait_idle("t3_drain", 200);

        // Reserved ATIDs are consumed but dropped
        acc_cnt[3] = 0;
        push_beat(3, 8'h00, 0, 1'b0);
        push_beat(3, 8'h72, 1, 1'b0);
        push_beat(3, 8'h10, 2, 1'b1);
        wait_idle("t4_drain", 50);
        check("t4_drop_cnt", 96'(drop_cnt), 96'(2));
        check("t4_accepted", 96'(acc_cnt[3]), 96'(3));

        // Sink stalls 10 cycles under a 4-beat packet
        send_pkt(2, 4, 0);
        stall_cnt = 10;
        for (int i = 0; i < 6; i++) tick();
        check("t5_src_ready", 96'(s_atready), 96'(0));
        check("t5_mvalid", 96'(m_atvalid), 96'(1));
        check("t5_head", 96'(m_atdata), 96'(mk_data(2, 0)));
        wait_idle("t5_drain", 60);

        // Flush while source 4 is mid-packet and source 5 is waiting
        send_pkt(4, 4, 0);
        send_pkt(5, 2, 0);
        tick();
        tick();
        flush_v = 1'b1;
        seen    = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            if (flush_done === 1'b1) seen = 1'b1;
        end
        check("t6_flush_seen", 96'(seen), 96'(1));
        check("t6_flush_drained", 96'(exp_q.size()), 96'(0));
        check("t6_flush_skid", 96'(m_atvalid), 96'(0));
        tick();
        check("t6_flush_pulse", 96'(flush_done), 96'(0));

        // Reset in the middle of a packet
        mon_en = 1'b0;
        send_pkt(4, 6, 100);
        for (int i = 0; i < 3; i++) tick();
        check("t6_pre_reset_busy", 96'(busy), 96'(1));
        src_q[4].delete();
        do_reset();
        exp_q.delete();
        reset_checks("t6_reset");
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("t6_post_reset_valid", 96'(m_atvalid), 96'(0));
        check("t6_post_reset_busy", 96'(busy), 96'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
